// File: rtl/geofence_pkg.sv
// geofence_pkg: shared coordinate, point and state definitions for the geofence point streamer
package geofence_pkg;
    localparam int COORD_W     = 10;
    localparam int PTS_PER_OBJ = 7;
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;
    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_SEND, S_WAIT, S_LOG, S_DONE} state_t;
endpackage

// File: rtl/geofence_point_streamer.sv
// geofence_point_streamer: streams object records from point RAM to the geofence core and logs one result per object
// Ports: clk/reset (sync, active-high); start begins a run; mem_addr/mem_rdata read point RAM (1-cycle latency);
// X/Y registered point to the core; valid/is_inside core result; res_we/res_addr/res_data result write;
// inside_cnt objects inside this run; busy during a run; done one-cycle end-of-run pulse.
module geofence_point_streamer
    import geofence_pkg::*;
#(
    parameter int NUM_OBJ = 16,
    parameter int TIMEOUT = 64,
    parameter int AW      = 7,
    localparam int OW     = NUM_OBJ > 1 ? $clog2(NUM_OBJ) : 1,
    localparam int WW     = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [AW-1:0]        mem_addr,
    input  logic [2*COORD_W-1:0] mem_rdata,
    output logic [COORD_W-1:0]   X,
    output logic [COORD_W-1:0]   Y,
    input  logic                 valid,
    input  logic                 is_inside,
    output logic                 res_we,
    output logic [OW-1:0]        res_addr,
    output logic [1:0]           res_data,
    output logic [OW:0]          inside_cnt,
    output logic                 busy,
    output logic                 done
);
    state_t        state, nxt;
    point_t        pt;
    logic [AW-1:0] addr, base;
    logic [2:0]    k;
    logic [WW-1:0] wcnt;
    logic [OW-1:0] obj;
    logic [OW:0]   cnt;
    logic          in_r, to_r;
    wire           last = obj == OW'(NUM_OBJ - 1);

    always_ff @(posedge clk) begin
        state <= reset ? S_IDLE : nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = start ? S_PRIME : S_IDLE;
            S_PRIME: nxt = S_SEND;
            S_SEND:  nxt = k == 3'(PTS_PER_OBJ - 1) ? S_WAIT : S_SEND;
            S_WAIT:  nxt = (valid || wcnt == WW'(TIMEOUT - 1)) ? S_LOG : S_WAIT;
            S_LOG:   nxt = last ? S_DONE : S_PRIME;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = state != S_IDLE;
        done     = state == S_DONE;
        res_we   = state == S_LOG;
        res_addr = res_we ? obj : '0;
        res_data = res_we ? {to_r, in_r} : 2'b00;
    end

    // Address runs one ahead of the data being captured; it stops at base+6 so no read strays past the record.
    always_ff @(posedge clk) begin
        if (reset) begin
            pt   <= '0;
            addr <= '0;
            base <= '0;
            k    <= '0;
            wcnt <= '0;
            obj  <= '0;
            cnt  <= '0;
            in_r <= 1'b0;
            to_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    addr <= '0;
                    base <= '0;
                    obj  <= '0;
                    cnt  <= '0;
                end
                S_PRIME: begin
                    addr <= addr + AW'(1);
                    k    <= '0;
                end
                S_SEND: begin
                    pt   <= point_t'(mem_rdata);
                    k    <= k + 3'd1;
                    wcnt <= '0;
                    if (k < 3'(PTS_PER_OBJ - 2)) addr <= addr + AW'(1);
                end
                S_WAIT: begin
                    wcnt <= wcnt + WW'(1);
                    in_r <= valid & is_inside;
                    to_r <= ~valid;
                end
                S_LOG: begin
                    cnt  <= cnt + (OW+1)'(in_r);
                    obj  <= obj + OW'(1);
                    base <= base + AW'(PTS_PER_OBJ);
                    if (!last) addr <= base + AW'(PTS_PER_OBJ);
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = addr;
    assign X          = pt.x;
    assign Y          = pt.y;
    assign inside_cnt = cnt;
endmodule

// File: tb/tb_geofence_point_streamer.sv
// tb_geofence_point_streamer: directed checks of the point streamer against a RAM model and a scripted core
module tb_geofence_point_streamer;
    localparam int N  = 4;
    localparam int TO = 64;
    localparam int AW = 7;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, valid = 1'b0, is_inside = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [19:0]   mem_rdata = '0;
    logic [9:0]    X, Y;
    logic          res_we, busy, done;
    logic [1:0]    res_addr, res_data;
    logic [2:0]    inside_cnt;
    logic [19:0]   mem [128];
    int            checks = 0, errors = 0, we_cnt = 0, done_cnt = 0;

    geofence_point_streamer #(.NUM_OBJ(N), .TIMEOUT(TO), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .X(X), .Y(Y), .valid(valid), .is_inside(is_inside), .res_we(res_we), .res_addr(res_addr),
        .res_data(res_data), .inside_cnt(inside_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_rdata <= mem[mem_addr];

    function automatic logic [9:0] px(input int a);
        return a == 0 ? 10'd500 : a == 1 ? 10'd0 : 10'(a * 7 + 5);
    endfunction

    function automatic logic [9:0] py(input int a);
        return a == 0 ? 10'd500 : a == 1 ? 10'd0 : 10'(1000 - a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        we_cnt   += int'(res_we);
        done_cnt += int'(done);
    endtask

    // Entered in PRIME of object o; leaves one cycle after LOG. w = WAIT cycles before valid (w >= TO: none).
    task automatic obj(input int o, input logic ins, input int w, input bit glitch);
        chk("prime_addr", 32'(mem_addr), 32'(o * 7));
        chk("prime_busy", 32'(busy), 32'd1);
        tick;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            valid     = glitch && i == 2;
            is_inside = glitch && i == 2;
            tick;
            chk("send_x", 32'(X), 32'(px(o * 7 + i)));
            chk("send_y", 32'(Y), 32'(py(o * 7 + i)));
        end
        valid     = 1'b0;
        is_inside = 1'b0;
        repeat (w < TO ? w : TO - 1) tick;
        chk("wait_hold_x", 32'(X), 32'(px(o * 7 + 6)));
        chk("wait_no_we", 32'(res_we), 32'd0);
        if (w < TO) begin
            valid     = 1'b1;
            is_inside = ins;
        end
        tick;
        valid     = 1'b0;
        is_inside = 1'b0;
        chk("log_we", 32'(res_we), 32'd1);
        chk("log_addr", 32'(res_addr), 32'(o));
        chk("log_data", 32'(res_data), 32'(w < TO ? {1'b0, ins} : 2'b10));
        tick;
    endtask

    initial begin
        for (int a = 0; a < 128; a++) mem[a] = {px(a), py(a)};
        tick;
        tick;
        chk("rst_x", 32'(X), 32'd0);
        chk("rst_y", 32'(Y), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(res_we), 32'd0);
        chk("rst_cnt", 32'(inside_cnt), 32'd0);
        reset = 1'b0;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        obj(0, 1'b1, 0, 1'b0);
        obj(1, 1'b0, 3, 1'b1);
        chk("cnt_after_obj1", 32'(inside_cnt), 32'd1);
        start = 1'b1;
        obj(2, 1'b1, 5, 1'b0);
        obj(3, 1'b1, 1, 1'b0);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_cnt", 32'(inside_cnt), 32'd3);
        chk("max_addr", 32'(mem_addr), 32'd27);
        tick;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_cnt_hold", 32'(inside_cnt), 32'd3);
        chk("run1_we_pulses", 32'(we_cnt), 32'd4);
        chk("run1_done_pulses", 32'(done_cnt), 32'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("cnt_cleared", 32'(inside_cnt), 32'd0);
        obj(0, 1'b1, TO, 1'b0);
        obj(1, 1'b1, TO - 1, 1'b0);
        chk("cnt_run2", 32'(inside_cnt), 32'd1);
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midrst_x", 32'(X), 32'd0);
        chk("midrst_y", 32'(Y), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cnt", 32'(inside_cnt), 32'd0);
        repeat (5) tick;
        chk("midrst_we_pulses", 32'(we_cnt), 32'd6);
        chk("midrst_done_pulses", 32'(done_cnt), 32'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        obj(0, 1'b0, 2, 1'b0);
        chk("run3_cnt", 32'(inside_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
